// File: rtl/pool_max_1.sv
// pool_max_1: pipelined 2x2 signed max-pooling for the first LeNet pooling layer.
// Two independent datapaths (port A -> result_1, port B -> result_2), three
// register stages: vertical max, horizontal max, output (optional ReLU).
// Optional feature macro: POOL_MAX_RELU_EN (clamps negative pooled pixels to 0).
module pool_max_1 #(
    parameter int DW      = 16,
    parameter int ROW_PIX = 28,
    parameter int WORDS   = 84
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        max_en,
    input  logic [2*ROW_PIX*DW-1:0]     fm_bram_1_douta,
    input  logic [2*ROW_PIX*DW-1:0]     fm_bram_1_doutb,
    output logic [ROW_PIX/2*DW-1:0]     pool_max_result_1,
    output logic [ROW_PIX/2*DW-1:0]     pool_max_result_2,
    output logic                        pool_max_vld,
    output logic [6:0]                  pool_max_cnt,
    output logic                        pool_max_done
);

    localparam int         OPIX   = ROW_PIX / 2;
    localparam logic [6:0] C_LAST = 7'(WORDS - 1);

    // Valid pipeline: r_vd[0] qualifies S1 data, r_vd[1] S2 data, r_vd[2] outputs.
    logic [2:0]             r_vd;
    logic signed [DW-1:0]   r_s1_a [ROW_PIX];
    logic signed [DW-1:0]   r_s1_b [ROW_PIX];
    logic signed [DW-1:0]   r_s2_a [OPIX];
    logic signed [DW-1:0]   r_s2_b [OPIX];
    logic [OPIX*DW-1:0]     r_res_a;
    logic [OPIX*DW-1:0]     r_res_b;
    logic [6:0]             r_cnt;

    function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] x,
                                                  input logic signed [DW-1:0] y);
        return (x > y) ? x : y;
    endfunction

    function automatic logic [DW-1:0] out_f(input logic signed [DW-1:0] h);
`ifdef POOL_MAX_RELU_EN
        return h[DW-1] ? '0 : h;
`else
        return h;
`endif
    endfunction

    // Carry max_en through the three stages; reset discards in-flight words.
    always_ff @(posedge clk) begin
        // NOTE: sequential state always uses non-blocking assignments so every
        // stage samples the previous cycle's values, independent of block order.
        if (rst) r_vd <= '0;
        else     r_vd <= {r_vd[1:0], max_en};
    end

    // S1: vertical max of upper (lanes ROW_PIX+c) and lower (lane c) row pixels.
    always_ff @(posedge clk) begin
        // NOTE: these register arrays are small flops, not RAM, so resetting them
        // is cheap and gives the zero state expected after reset.
        if (rst) begin
            for (int c = 0; c < ROW_PIX; c++) begin
                r_s1_a[c] <= '0;
                r_s1_b[c] <= '0;
            end
        end else if (max_en) begin
            for (int c = 0; c < ROW_PIX; c++) begin
                r_s1_a[c] <= smax(fm_bram_1_douta[(ROW_PIX+c)*DW +: DW],
                                  fm_bram_1_douta[c*DW +: DW]);
                r_s1_b[c] <= smax(fm_bram_1_doutb[(ROW_PIX+c)*DW +: DW],
                                  fm_bram_1_doutb[c*DW +: DW]);
            end
        end
    end

    // S2: horizontal max of adjacent column pairs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < OPIX; j++) begin
                r_s2_a[j] <= '0;
                r_s2_b[j] <= '0;
            end
        end else if (r_vd[0]) begin
            for (int j = 0; j < OPIX; j++) begin
                r_s2_a[j] <= smax(r_s1_a[2*j], r_s1_a[2*j+1]);
                r_s2_b[j] <= smax(r_s1_b[2*j], r_s1_b[2*j+1]);
            end
        end
    end

    // S3: output registers; hold the last result while no new word arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_a <= '0;
            r_res_b <= '0;
        end else if (r_vd[1]) begin
            for (int j = 0; j < OPIX; j++) begin
                r_res_a[j*DW +: DW] <= out_f(r_s2_a[j]);
                r_res_b[j*DW +: DW] <= out_f(r_s2_b[j]);
            end
        end
    end

    // Result counter for the current pass; wraps straight back to 0 after the last word.
    always_ff @(posedge clk) begin
        if (rst)          r_cnt <= '0;
        else if (r_vd[2]) r_cnt <= (r_cnt == C_LAST) ? '0 : r_cnt + 7'd1;
    end

    assign pool_max_result_1 = r_res_a;
    assign pool_max_result_2 = r_res_b;
    assign pool_max_vld      = r_vd[2];
    assign pool_max_cnt      = r_cnt;
    assign pool_max_done     = r_vd[2] && (r_cnt == C_LAST);

endmodule

// File: tb/tb_pool_max_1.sv
// tb_pool_max_1: self-checking bench for pool_max_1 with a queue-based
// reference model (pooled results scheduled for delivery 3 cycles after max_en).
module tb_pool_max_1;

    localparam int DW      = 16;
    localparam int ROW_PIX = 28;
    localparam int WORDS   = 84;
    localparam int IW      = 2 * ROW_PIX * DW;
    localparam int OW      = ROW_PIX / 2 * DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          max_en = 1'b0;
    logic [IW-1:0] douta = '0;
    logic [IW-1:0] doutb = '0;
    logic [OW-1:0] pool_max_result_1;
    logic [OW-1:0] pool_max_result_2;
    logic          pool_max_vld;
    logic [6:0]    pool_max_cnt;
    logic          pool_max_done;

    pool_max_1 #(.DW(DW), .ROW_PIX(ROW_PIX), .WORDS(WORDS)) dut (
        .clk               (clk),
        .rst               (rst),
        .max_en            (max_en),
        .fm_bram_1_douta   (douta),
        .fm_bram_1_doutb   (doutb),
        .pool_max_result_1 (pool_max_result_1),
        .pool_max_result_2 (pool_max_result_2),
        .pool_max_vld      (pool_max_vld),
        .pool_max_cnt      (pool_max_cnt),
        .pool_max_done     (pool_max_done)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int edge_n = 0;

    typedef struct {
        int          due;
        logic [OW-1:0] r1;
        logic [OW-1:0] r2;
    } exp_t;

    exp_t          q[$];
    logic          m_vld = 1'b0;
    logic          m_done = 1'b0;
    logic [6:0]    m_cnt = '0;
    logic [OW-1:0] m_r1 = '0;
    logic [OW-1:0] m_r2 = '0;

    // Reference pooling: signed max of the four pixels of each 2x2 window.
    function automatic logic [OW-1:0] pool_ref(input logic [IW-1:0] w);
        logic [OW-1:0] r;
        int m;
        int x;
        r = '0;
        for (int j = 0; j < ROW_PIX / 2; j++) begin
            m = $signed(w[(2*j)*DW +: DW]);
            x = $signed(w[(2*j+1)*DW +: DW]);         if (x > m) m = x;
            x = $signed(w[(ROW_PIX+2*j)*DW +: DW]);   if (x > m) m = x;
            x = $signed(w[(ROW_PIX+2*j+1)*DW +: DW]); if (x > m) m = x;
`ifdef POOL_MAX_RELU_EN
            if (m < 0) m = 0;
`endif
            r[j*DW +: DW] = m[DW-1:0];
        end
        return r;
    endfunction

    function automatic logic [IW-1:0] fill(input int v);
        logic [IW-1:0] w;
        for (int k = 0; k < 2 * ROW_PIX; k++) w[k*DW +: DW] = v[DW-1:0];
        return w;
    endfunction

    function automatic logic [IW-1:0] rand_word();
        logic [IW-1:0] w;
        for (int k = 0; k < 2 * ROW_PIX; k++) w[k*DW +: DW] = 16'($urandom);
        return w;
    endfunction

    // Advance one clock and update the expected outputs from the inputs seen at that edge.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        edge_n++;
        if (rst) begin
            q.delete();
            m_vld = 1'b0; m_done = 1'b0; m_cnt = '0; m_r1 = '0; m_r2 = '0;
        end else begin
            if (m_vld) m_cnt = (m_cnt == 7'(WORDS - 1)) ? 7'd0 : m_cnt + 7'd1;
            m_vld = 1'b0;
            m_done = 1'b0;
            if (max_en) begin
                e.due = edge_n + 2;
                e.r1  = pool_ref(douta);
                e.r2  = pool_ref(doutb);
                q.push_back(e);
            end
            if (q.size() > 0 && q[0].due == edge_n) begin
                e = q.pop_front();
                m_vld  = 1'b1;
                m_done = (m_cnt == 7'(WORDS - 1));
                m_r1   = e.r1;
                m_r2   = e.r2;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; max_en = 1'b1; douta = rand_word(); doutb = rand_word();
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin rst = 1'b0; max_en = 1'b0; end
            tick();
            n_total++;
            if ({pool_max_vld, pool_max_done, pool_max_cnt, pool_max_result_1, pool_max_result_2}
                !== {m_vld, m_done, m_cnt, m_r1, m_r2})
                $display("FAIL reset edge %0d: got vld=%b done=%b cnt=%0d r1=%h r2=%h want vld=%b done=%b cnt=%0d r1=%h r2=%h",
                         edge_n, pool_max_vld, pool_max_done, pool_max_cnt, pool_max_result_1, pool_max_result_2,
                         m_vld, m_done, m_cnt, m_r1, m_r2);
            else n_pass++;
        end
    endtask

    task automatic test_single();
        for (int k = 0; k < 2 * ROW_PIX; k++) douta[k*DW +: DW] = 16'(k);
        doutb = rand_word();
        max_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            max_en = 1'b0;
            n_total++;
            if ({pool_max_vld, pool_max_done, pool_max_cnt, pool_max_result_1, pool_max_result_2}
                !== {m_vld, m_done, m_cnt, m_r1, m_r2})
                $display("FAIL single edge %0d: got vld=%b done=%b cnt=%0d r1=%h r2=%h want vld=%b done=%b cnt=%0d r1=%h r2=%h",
                         edge_n, pool_max_vld, pool_max_done, pool_max_cnt, pool_max_result_1, pool_max_result_2,
                         m_vld, m_done, m_cnt, m_r1, m_r2);
            else n_pass++;
            if (i == 2) begin
                n_total++;
                if (pool_max_vld !== 1'b1 || pool_max_result_1[0 +: DW] !== 16'd29 ||
                    pool_max_result_1[13*DW +: DW] !== 16'd55)
                    $display("FAIL single_lanes: got vld=%b lane0=%0d lane13=%0d want vld=1 lane0=29 lane13=55",
                             pool_max_vld, pool_max_result_1[0 +: DW], pool_max_result_1[13*DW +: DW]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_signed();
        logic [DW-1:0] want1;
        logic [DW-1:0] want_other;
`ifdef POOL_MAX_RELU_EN
        want1 = 16'h0000; want_other = 16'h0000;
`else
        want1 = 16'hFFFF; want_other = 16'h8000;
`endif
        douta = rand_word();
        doutb = fill(32'h8000);
        doutb[31*DW +: DW] = 16'hFFFF;
        max_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            max_en = 1'b0;
            n_total++;
            if ({pool_max_vld, pool_max_done, pool_max_cnt, pool_max_result_1, pool_max_result_2}
                !== {m_vld, m_done, m_cnt, m_r1, m_r2})
                $display("FAIL signed edge %0d: got vld=%b done=%b cnt=%0d r1=%h r2=%h want vld=%b done=%b cnt=%0d r1=%h r2=%h",
                         edge_n, pool_max_vld, pool_max_done, pool_max_cnt, pool_max_result_1, pool_max_result_2,
                         m_vld, m_done, m_cnt, m_r1, m_r2);
            else n_pass++;
        end
        n_total++;
        if (pool_max_result_2[1*DW +: DW] !== want1 || pool_max_result_2[0 +: DW] !== want_other ||
            pool_max_result_2[13*DW +: DW] !== want_other)
            $display("FAIL signed_lanes: got lane1=%h lane0=%h lane13=%h want lane1=%h others=%h",
                     pool_max_result_2[1*DW +: DW], pool_max_result_2[0 +: DW],
                     pool_max_result_2[13*DW +: DW], want1, want_other);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int  res_idx = 0;
        int  done_cnt = 0;
        int  done_idx = -1;
        bit  chk_next = 1'b0;
        rst = 1'b1; max_en = 1'b0;
        tick();
        rst = 1'b0;
        for (int n = 0; n < WORDS + 4; n++) begin
            max_en = (n < WORDS);
            douta  = fill(n);
            doutb  = rand_word();
            tick();
            n_total++;
            if ({pool_max_vld, pool_max_done, pool_max_cnt, pool_max_result_1, pool_max_result_2}
                !== {m_vld, m_done, m_cnt, m_r1, m_r2})
                $display("FAIL b2b edge %0d: got vld=%b done=%b cnt=%0d r1=%h r2=%h want vld=%b done=%b cnt=%0d r1=%h r2=%h",
                         edge_n, pool_max_vld, pool_max_done, pool_max_cnt, pool_max_result_1, pool_max_result_2,
                         m_vld, m_done, m_cnt, m_r1, m_r2);
            else n_pass++;
            if (chk_next) begin
                chk_next = 1'b0;
                n_total++;
                if (pool_max_cnt !== 7'd0)
                    $display("FAIL b2b_wrap: got cnt=%0d want 0", pool_max_cnt);
                else n_pass++;
            end
            if (pool_max_vld === 1'b1) begin
                n_total++;
                if (pool_max_result_1[5*DW +: DW] !== 16'(res_idx))
                    $display("FAIL b2b_order: got %0d want %0d", pool_max_result_1[5*DW +: DW], res_idx);
                else n_pass++;
                if (pool_max_done === 1'b1) begin
                    done_cnt++;
                    done_idx = res_idx;
                    chk_next = 1'b1;
                end
                res_idx++;
            end
        end
        max_en = 1'b0;
        n_total++;
        if (done_cnt != 1 || done_idx != WORDS - 1 || res_idx != WORDS)
            $display("FAIL b2b_done: got dones=%0d at result %0d of %0d want 1 at %0d of %0d",
                     done_cnt, done_idx, res_idx, WORDS - 1, WORDS);
        else n_pass++;
    endtask

    task automatic test_bubbles();
        logic          vseq [6];
        logic [DW-1:0] lseq [6];
        for (int i = 0; i < 6; i++) begin
            max_en = (i == 0 || i == 2);
            douta  = (i == 2) ? fill(9) : fill(5);
            doutb  = rand_word();
            tick();
            vseq[i] = pool_max_vld;
            lseq[i] = pool_max_result_1[0 +: DW];
            n_total++;
            if ({pool_max_vld, pool_max_done, pool_max_cnt, pool_max_result_1, pool_max_result_2}
                !== {m_vld, m_done, m_cnt, m_r1, m_r2})
                $display("FAIL bubbles edge %0d: got vld=%b done=%b cnt=%0d r1=%h r2=%h want vld=%b done=%b cnt=%0d r1=%h r2=%h",
                         edge_n, pool_max_vld, pool_max_done, pool_max_cnt, pool_max_result_1, pool_max_result_2,
                         m_vld, m_done, m_cnt, m_r1, m_r2);
            else n_pass++;
        end
        max_en = 1'b0;
        n_total++;
        if ({vseq[2], vseq[3], vseq[4]} !== 3'b101 || lseq[2] !== 16'd5 ||
            lseq[3] !== 16'd5 || lseq[4] !== 16'd9)
            $display("FAIL bubbles_seq: got vld=%b%b%b lane0=%0d,%0d,%0d want vld=101 lane0=5,5,9",
                     vseq[2], vseq[3], vseq[4], lseq[2], lseq[3], lseq[4]);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        douta = fill(7); doutb = rand_word(); max_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rst = (i == 1);
            tick();
            max_en = 1'b0;
            n_total++;
            if ({pool_max_vld, pool_max_done, pool_max_cnt, pool_max_result_1, pool_max_result_2}
                !== {m_vld, m_done, m_cnt, m_r1, m_r2})
                $display("FAIL reset_mid edge %0d: got vld=%b done=%b cnt=%0d r1=%h r2=%h want vld=%b done=%b cnt=%0d r1=%h r2=%h",
                         edge_n, pool_max_vld, pool_max_done, pool_max_cnt, pool_max_result_1, pool_max_result_2,
                         m_vld, m_done, m_cnt, m_r1, m_r2);
            else n_pass++;
            if (i == 2) begin
                n_total++;
                if (pool_max_vld !== 1'b0 || pool_max_cnt !== 7'd0 ||
                    pool_max_result_1 !== '0 || pool_max_result_2 !== '0)
                    $display("FAIL reset_mid_flush: got vld=%b cnt=%0d r1=%h r2=%h want vld=0 cnt=0 outputs=0",
                             pool_max_vld, pool_max_cnt, pool_max_result_1, pool_max_result_2);
                else n_pass++;
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            max_en = ($urandom_range(0, 3) != 0);
            rst    = ($urandom_range(0, 99) == 0);
            douta  = rand_word();
            doutb  = rand_word();
            tick();
            n_total++;
            if ({pool_max_vld, pool_max_done, pool_max_cnt, pool_max_result_1, pool_max_result_2}
                !== {m_vld, m_done, m_cnt, m_r1, m_r2})
                $display("FAIL random edge %0d: got vld=%b done=%b cnt=%0d r1=%h r2=%h want vld=%b done=%b cnt=%0d r1=%h r2=%h",
                         edge_n, pool_max_vld, pool_max_done, pool_max_cnt, pool_max_result_1, pool_max_result_2,
                         m_vld, m_done, m_cnt, m_r1, m_r2);
            else n_pass++;
        end
        rst = 1'b0; max_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_signed();
        test_back_to_back();
        test_bubbles();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
